// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: opcodes common to Decode/Execute/Memory
// and the memory-stage state encoding.
package cpu_pkg;

    localparam logic [4:0] SUB   = 5'b00001;
    localparam logic [4:0] LOAD  = 5'b01000;
    localparam logic [4:0] STORE = 5'b01001;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == LOAD) || (op == STORE);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and memory (slave).
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a memory ack; expired marks the last
// cycle before the access must be aborted.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (clear)              cnt <= '0;
        else if (enable && !expired) cnt <= cnt + W'(1);
    end

    assign expired = (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: registers Execute results, runs LOAD/STORE over a
// req/ack bus with timeout abort, and emits one retire pulse per instruction.
module memory_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [4:0]            control_in,
    input  logic [4:0]            dest_index_in,
    input  logic [15:0]           result_in,
    input  logic [15:0]           store_data,
    input  logic                  reg_write_en_in,
    output logic                  stall,
    memory_stage_if.master        mem,
    output logic                  wb_valid,
    output logic [4:0]            wb_control,
    output logic [4:0]            wb_dest_index,
    output logic [15:0]           wb_data,
    output logic                  wb_reg_write_en,
    output logic                  mem_err
);
    logic [0:0] state;
    logic [4:0] ctl_q;
    logic [4:0] dest_q;
    logic       rwe_q;
    logic       accept_mem;
    logic       expired;

    assign accept_mem = (state == IDLE) && ex_valid && is_mem_op(control_in);
    assign stall      = (state == ACCESS);

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept_mem),
        .enable  ((state == ACCESS) && !mem.ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ctl_q           <= '0;
            dest_q          <= '0;
            rwe_q           <= 1'b0;
            mem.req         <= 1'b0;
            mem.we          <= 1'b0;
            mem.addr        <= '0;
            mem.wdata       <= '0;
            wb_valid        <= 1'b0;
            wb_control      <= '0;
            wb_dest_index   <= '0;
            wb_data         <= '0;
            wb_reg_write_en <= 1'b0;
            mem_err         <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: if (ex_valid) begin
                    if (is_mem_op(control_in)) begin
                        state     <= ACCESS;
                        ctl_q     <= control_in;
                        dest_q    <= dest_index_in;
                        rwe_q     <= reg_write_en_in;
                        mem.req   <= 1'b1;
                        mem.we    <= (control_in == STORE);
                        mem.addr  <= result_in;
                        mem.wdata <= store_data;
                    end else begin
                        wb_valid        <= 1'b1;
                        wb_control      <= control_in;
                        wb_dest_index   <= dest_index_in;
                        wb_data         <= result_in;
                        wb_reg_write_en <= reg_write_en_in;
                    end
                end
                ACCESS: if (mem.ack || expired) begin
                    // ack is checked first so an ack on the final cycle still completes
                    state         <= IDLE;
                    mem.req       <= 1'b0;
                    wb_valid      <= 1'b1;
                    wb_control    <= ctl_q;
                    wb_dest_index <= dest_q;
                    if (!mem.ack) begin
                        mem_err         <= 1'b1;
                        wb_data         <= '0;
                        wb_reg_write_en <= 1'b0;
                    end else if (mem.we) begin
                        wb_data         <= mem.addr;
                        wb_reg_write_en <= 1'b0;
                    end else begin
                        wb_data         <= mem.rdata;
                        wb_reg_write_en <= rwe_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: random instruction stream, a memory
// responder with chosen ack delays, and directed reset/timeout cases.
module tb_memory_stage;
    import cpu_pkg::*;

    localparam int TO = 4;

    typedef struct {
        logic [4:0]  ctl;
        logic [4:0]  dest;
        logic [15:0] data;
        logic        rwe;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
    } acc_t;

    logic clk = 0;
    logic rst_n = 0;
    logic ex_valid = 0;
    logic [4:0] control_in = '0;
    logic [4:0] dest_index_in = '0;
    logic [15:0] result_in = '0;
    logic [15:0] store_data = '0;
    logic reg_write_en_in = 0;
    logic stall, wb_valid, wb_reg_write_en, mem_err;
    logic [4:0] wb_control, wb_dest_index;
    logic [15:0] wb_data;

    memory_stage_if mif();

    memory_stage #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .control_in      (control_in),
        .dest_index_in   (dest_index_in),
        .result_in       (result_in),
        .store_data      (store_data),
        .reg_write_en_in (reg_write_en_in),
        .stall           (stall),
        .mem             (mif.master),
        .wb_valid        (wb_valid),
        .wb_control      (wb_control),
        .wb_dest_index   (wb_dest_index),
        .wb_data         (wb_data),
        .wb_reg_write_en (wb_reg_write_en),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    acc_t acc_q[$];
    bit resp_en = 1;

    // Monitor: every retire must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_retire got ctl=%h data=%h", wb_control, wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({wb_control, wb_dest_index, wb_data, wb_reg_write_en, mem_err} !==
                    {e.ctl, e.dest, e.data, e.rwe, e.err}) begin
                    failures++;
                    $display("FAIL retire got ctl=%h dest=%h data=%h rwe=%b err=%b exp ctl=%h dest=%h data=%h rwe=%b err=%b",
                             wb_control, wb_dest_index, wb_data, wb_reg_write_en, mem_err,
                             e.ctl, e.dest, e.data, e.rwe, e.err);
                end
            end
        end else if (rst_n && mem_err) begin
            checks++;
            failures++;
            $display("FAIL mem_err_without_retire");
        end
    end

    // Memory responder: checks request contents and how long req/stall stay high.
    bit busy = 0;
    int cyc = 0, stall_cyc = 0;
    acc_t cur;
    always @(negedge clk) begin
        if (!resp_en) begin
            busy = 0;
        end else if (mif.req) begin
            if (!busy) begin
                busy = 1; cyc = 0; stall_cyc = 0;
                checks++;
                if (acc_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req addr=%h", mif.addr);
                    cur = '{we:0, addr:0, wdata:0, rdata:0, delay:TO + 1};
                end else begin
                    cur = acc_q.pop_front();
                    if ({mif.we, mif.addr} !== {cur.we, cur.addr} || (cur.we && mif.wdata !== cur.wdata)) begin
                        failures++;
                        $display("FAIL req_fields got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                                 mif.we, mif.addr, mif.wdata, cur.we, cur.addr, cur.wdata);
                    end
                end
            end
            cyc++;
            if (stall) stall_cyc++;
            mif.ack   = (cyc == cur.delay);
            mif.rdata = mif.ack ? cur.rdata : 16'($urandom);
        end else begin
            if (busy) begin
                int want;
                busy = 0;
                want = (cur.delay <= TO) ? cur.delay : TO;
                checks++;
                if (cyc != want || stall_cyc != want || stall !== 1'b0) begin
                    failures++;
                    $display("FAIL req_duration got req=%0d stall=%0d stall_now=%b exp %0d", cyc, stall_cyc, stall, want);
                end
            end
            mif.ack   = ($urandom_range(0, 3) == 0);  // stray acks must be ignored
            mif.rdata = 16'($urandom);
        end
    end

    // Reference: retire contents follow directly from opcode and chosen ack delay.
    task automatic issue(input logic [4:0] op, input logic [4:0] dest, input logic [15:0] res,
                         input logic [15:0] sd, input logic rwe, input int delay, input logic [15:0] rdata);
        exp_t e;
        acc_t a;
        int waitc;
        ex_valid = 1; control_in = op; dest_index_in = dest;
        result_in = res; store_data = sd; reg_write_en_in = rwe;
        waitc = 0;
        while (stall && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (stall) begin
            checks++; failures++;
            $display("FAIL accept_timeout stall stuck at %b", stall);
        end
        e.ctl = op; e.dest = dest; e.err = 0;
        if (op != LOAD && op != STORE) begin
            e.data = res; e.rwe = rwe;
        end else begin
            if (delay > TO) begin
                e.data = 0; e.rwe = 0; e.err = 1;
            end else if (op == STORE) begin
                e.data = res; e.rwe = 0;
            end else begin
                e.data = rdata; e.rwe = rwe;
            end
            a.we = (op == STORE); a.addr = res; a.wdata = sd; a.rdata = rdata; a.delay = delay;
            acc_q.push_back(a);
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        ex_valid = 0;
        n = 0;
        while ((exp_q.size() != 0 || stall) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain outstanding=%0d exp 0", exp_q.size());
        end
    endtask

    initial begin
        logic [4:0] op;
        repeat (3) @(negedge clk);
        checks++;
        if ({mif.req, mif.we, mif.addr, mif.wdata, stall, wb_valid, mem_err, wb_data, wb_control,
             wb_dest_index, wb_reg_write_en} !== '0) begin
            failures++;
            $display("FAIL reset_state req=%b stall=%b wb_valid=%b wb_data=%h addr=%h exp all 0",
                     mif.req, stall, wb_valid, wb_data, mif.addr);
        end
        rst_n = 1;
        @(negedge clk);

        issue(SUB,   5'd2, 16'd7,      16'h0,    1'b1, 0, 16'h0);
        issue(LOAD,  5'd3, 16'h0040,   16'h0,    1'b1, 3, 16'hBEEF);
        issue(STORE, 5'd4, 16'h0010,   16'h1234, 1'b1, 1, 16'h0);
        issue(LOAD,  5'd5, 16'h0080,   16'h0,    1'b1, TO + 5, 16'h5555);
        issue(LOAD,  5'd6, 16'h0084,   16'h0,    1'b1, TO, 16'hA5A5);
        issue(SUB,   5'd7, 16'hFFFF,   16'h0,    1'b0, 0, 16'h0);
        drain();

        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 3)      op = LOAD;
            else if (k < 5) op = STORE;
            else if (k < 6) op = SUB;
            else begin
                op = 5'($urandom);
                if (op == LOAD || op == STORE) op = 5'd0;
            end
            issue(op, 5'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(1, TO + 2), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                ex_valid = 0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();

        // Reset in the middle of an access discards it without a retire.
        resp_en = 0;
        mif.ack = 0;
        ex_valid = 1; control_in = LOAD; dest_index_in = 5'd9; result_in = 16'h0200;
        reg_write_en_in = 1;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 0;
        checks++;
        if ({mif.req, stall} !== 2'b11) begin
            failures++;
            $display("FAIL access_started req=%b stall=%b exp 1 1", mif.req, stall);
        end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({mif.req, stall, wb_valid} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset req=%b stall=%b wb_valid=%b exp 0 0 0", mif.req, stall, wb_valid);
        end
        @(negedge clk);
        rst_n = 1;
        mif.ack = 1;
        mif.rdata = 16'hDEAD;
        @(negedge clk);
        mif.ack = 0;
        checks++;
        if ({mif.req, stall, wb_valid} !== 3'b000) begin
            failures++;
            $display("FAIL stray_ack req=%b stall=%b wb_valid=%b exp 0 0 0", mif.req, stall, wb_valid);
        end
        resp_en = 1;
        issue(SUB, 5'd2, 16'd7, 16'h0, 1'b1, 0, 16'h0);
        drain();

        checks++;
        if (acc_q.size() != 0) begin
            failures++;
            $display("FAIL unserved_accesses got %0d exp 0", acc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
